// File: rtl/razor_recovery_ctrl.sv
// razor_recovery_ctrl: razor error recovery sequencing plus error-rate driven supply-voltage requests
// Ports:
//   i_clk, i_rst_n (async, active low), i_err_in: sticky per-stage razor error flags
//   o_stall: pipeline stall; o_restore_sel: shadow-latch select; o_flush: bubble insert downstream of earliest error
//   o_err_clr: razor clear; o_recover_done: completion pulse; o_fatal: error persisted through clear
//   o_vdd_up / o_vdd_down: window-end voltage requests; o_err_total: saturating event count
module razor_recovery_ctrl #(
  parameter int NUM_STAGES    = 5,
  parameter int REPLAY_CYCLES = 1,
  parameter int WINDOW        = 256,
  parameter int HI_THRESH     = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_STAGES-1:0] i_err_in,
  output logic                  o_stall,
  output logic [NUM_STAGES-1:0] o_restore_sel,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic                  o_err_clr,
  output logic                  o_recover_done,
  output logic                  o_fatal,
  output logic                  o_vdd_up,
  output logic                  o_vdd_down,
  output logic [CNT_W-1:0]      o_err_total
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int EV_W  = $clog2(HI_THRESH + 1);
  typedef enum logic [2:0] {IDLE, RESTORE, CLEAR, MASK, HALT} state_t;
  state_t                r_state;
  logic [3:0]            r_rc;
  logic [WIN_W-1:0]      r_win;
  logic [EV_W-1:0]       r_ev;
  logic [NUM_STAGES-1:0] w_low;
  logic [NUM_STAGES-1:0] w_flush;
  logic                  w_event;
  logic                  w_wend;
  // Isolate the earliest erring stage; every later stage gets a bubble.
  assign w_low   = i_err_in & (~i_err_in + NUM_STAGES'(1));
  assign w_flush = ~(w_low | (w_low - NUM_STAGES'(1)));
  assign w_event = (r_state == IDLE) && |i_err_in;
  assign w_wend  = r_win == WIN_W'(WINDOW - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_rc           <= '0;
      r_win          <= '0;
      r_ev           <= '0;
      o_stall        <= 1'b0;
      o_restore_sel  <= '0;
      o_flush        <= '0;
      o_err_clr      <= 1'b0;
      o_recover_done <= 1'b0;
      o_fatal        <= 1'b0;
      o_vdd_up       <= 1'b0;
      o_vdd_down     <= 1'b0;
      o_err_total    <= '0;
    end else begin
      o_recover_done <= 1'b0;
      case (r_state)
        IDLE: if (|i_err_in) begin
          r_state       <= RESTORE;
          r_rc          <= '0;
          o_stall       <= 1'b1;
          o_restore_sel <= i_err_in;
          o_flush       <= w_flush;
        end
        RESTORE: if (r_rc == 4'(REPLAY_CYCLES - 1)) begin
          r_state       <= CLEAR;
          o_err_clr     <= 1'b1;
          o_restore_sel <= '0;
          o_flush       <= '0;
        end else r_rc <= r_rc + 4'd1;
        CLEAR: begin
          r_state   <= MASK;
          o_err_clr <= 1'b0;
        end
        MASK: if (|i_err_in) begin
          r_state <= HALT;
          o_fatal <= 1'b1;
        end else begin
          r_state        <= IDLE;
          o_stall        <= 1'b0;
          o_recover_done <= 1'b1;
        end
        HALT: ;
        default: r_state <= IDLE;
      endcase
      if (w_event && o_err_total != '1) o_err_total <= o_err_total + CNT_W'(1);
      // Window bookkeeping freezes in HALT; an event on the wrap edge opens the new window.
      if (r_state != HALT) begin
        r_win      <= w_wend ? '0 : r_win + WIN_W'(1);
        o_vdd_up   <= w_wend && r_ev >= EV_W'(HI_THRESH);
        o_vdd_down <= w_wend && r_ev == '0;
        r_ev       <= w_wend ? EV_W'(w_event) : (w_event && r_ev != EV_W'(HI_THRESH)) ? r_ev + EV_W'(1) : r_ev;
      end else begin
        o_vdd_up   <= 1'b0;
        o_vdd_down <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// tb_razor_recovery_ctrl: scoreboard-driven directed bench for razor_recovery_ctrl
module tb_razor_recovery_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] err, err2;
  logic       stall, clr, done, fatal, up, down;
  logic [4:0] rsel, flush;
  logic [2:0] total;
  logic       stall2, clr2, done2, fatal2, up2, down2;
  logic [4:0] rsel2, flush2;
  logic [7:0] total2;
  typedef struct {int cyc; int sel; logic [7:0] v; string tag;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;
  razor_recovery_ctrl #(.NUM_STAGES(5), .REPLAY_CYCLES(1), .WINDOW(16), .HI_THRESH(2), .CNT_W(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_err_in(err), .o_stall(stall), .o_restore_sel(rsel), .o_flush(flush),
    .o_err_clr(clr), .o_recover_done(done), .o_fatal(fatal), .o_vdd_up(up), .o_vdd_down(down), .o_err_total(total));
  razor_recovery_ctrl #(.NUM_STAGES(5), .REPLAY_CYCLES(3), .WINDOW(16), .HI_THRESH(2), .CNT_W(8)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_err_in(err2), .o_stall(stall2), .o_restore_sel(rsel2), .o_flush(flush2),
    .o_err_clr(clr2), .o_recover_done(done2), .o_fatal(fatal2), .o_vdd_up(up2), .o_vdd_down(down2), .o_err_total(total2));
  always #5 clk = ~clk;
  function automatic logic [7:0] obs(int sel);
    case (sel)
      0: return 8'(stall);
      1: return 8'(rsel);
      2: return 8'(flush);
      3: return 8'(clr);
      4: return 8'(done);
      5: return 8'(fatal);
      6: return 8'(up);
      7: return 8'(down);
      8: return 8'(total);
      10: return 8'(stall2);
      11: return 8'(rsel2);
      12: return 8'(flush2);
      13: return 8'(clr2);
      14: return 8'(done2);
      default: return 8'hxx;
    endcase
  endfunction
  task automatic chk(string tag, logic [7:0] o, logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic ex(int c, int sel, logic [7:0] v, string tag);
    sb.push_back('{c, sel, v, tag});
  endtask
  task automatic step();
    int i = 0;
    @(posedge clk);
    cyc++;
    #1;
    while (i < sb.size())
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, obs(sb[i].sel), sb[i].v);
        sb.delete(i);
      end else i++;
    chk("vdd_excl", 8'(up & down), 8'd0);
  endtask
  task automatic run_to(int c);
    while (cyc < c) step();
  endtask
  // One recovery on u1: error driven in cycle c, dropped once err_clr is seen.
  task automatic ev(int c, logic [4:0] v, logic [4:0] fl, logic [7:0] tot);
    ex(c+1, 0, 1, "rst_stall"); ex(c+1, 1, 8'(v), "rst_rsel"); ex(c+1, 2, 8'(fl), "rst_flush"); ex(c+1, 3, 0, "rst_clr");
    ex(c+2, 0, 1, "clr_stall"); ex(c+2, 3, 1, "clr_clr"); ex(c+2, 1, 0, "clr_rsel"); ex(c+2, 2, 0, "clr_flush");
    ex(c+3, 0, 1, "mask_stall"); ex(c+3, 3, 0, "mask_clr"); ex(c+3, 4, 0, "mask_done");
    ex(c+4, 0, 0, "idle_stall"); ex(c+4, 4, 1, "done"); ex(c+4, 8, tot, "total"); ex(c+5, 4, 0, "done_pulse");
    run_to(c);
    err = v;
    run_to(c+2);
    err = '0;
  endtask
  initial begin
    rst_n = 1'b0;
    err   = '0;
    err2  = '0;
    #12;
    for (int s = 0; s < 9; s++) chk("reset_u1", obs(s), 8'd0);
    for (int s = 10; s < 15; s++) chk("reset_u2", obs(s), 8'd0);
    #10 rst_n = 1'b1;
    cyc = 0;
    ex(16, 6, 0, "w0_up"); ex(16, 7, 0, "w0_down");
    ex(32, 6, 1, "w1_up"); ex(32, 7, 0, "w1_down"); ex(33, 6, 0, "w1_up_pulse");
    ex(48, 7, 1, "w2_down"); ex(48, 6, 0, "w2_up"); ex(49, 7, 0, "w2_down_pulse");
    ex(64, 6, 0, "wend_ev_up"); ex(64, 7, 0, "wend_ev_down");
    ex(80, 6, 0, "carry_up"); ex(80, 7, 0, "carry_down");
    ex(96, 6, 1, "w5_up");
    ex(11, 10, 1, "r3_stall"); ex(11, 11, 8'h02, "r3_rsel"); ex(11, 12, 8'h1c, "r3_flush");
    ex(13, 10, 1, "r3_stall_hold"); ex(13, 11, 8'h02, "r3_rsel_hold"); ex(13, 13, 0, "r3_clr_early");
    ex(14, 13, 1, "r3_clr"); ex(14, 11, 0, "r3_clr_rsel");
    ex(15, 10, 1, "r3_mask_stall"); ex(15, 13, 0, "r3_mask_clr"); ex(15, 14, 0, "r3_done_early");
    ex(16, 10, 0, "r3_idle_stall"); ex(16, 14, 1, "r3_done"); ex(17, 14, 0, "r3_done_pulse");
    run_to(10);
    err2 = 5'b00010;
    ev(10, 5'b00100, 5'b11000, 1);
    run_to(14);
    err2 = '0;
    ev(17, 5'b01010, 5'b11100, 2);
    ev(22, 5'b00001, 5'b11110, 3);
    ev(50, 5'b00110, 5'b11100, 4);
    ev(63, 5'b10000, 5'b00000, 5);
    for (int i = 0; i < 4; i++) ev(82 + 4*i, 5'b00010, 5'b11100, (6 + i > 7) ? 8'd7 : 8'(6 + i));
    run_to(100);
    chk("sb_drain1", 8'(sb.size()), 8'd0);
    err = 5'b00001;
    step();
    chk("pre_rst_stall", 8'(stall), 8'd1);
    chk("pre_rst_total", 8'(total), 8'd7);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 9; s++) chk("async_rst", obs(s), 8'd0);
    err = '0;
    #2 rst_n = 1'b1;
    cyc = 0;
    ex(9, 0, 1, "halt_stall"); ex(9, 5, 1, "halt_fatal"); ex(9, 3, 0, "halt_clr"); ex(9, 1, 0, "halt_rsel");
    ex(9, 2, 0, "halt_flush"); ex(9, 4, 0, "halt_done"); ex(8, 5, 0, "mask_fatal");
    ex(32, 7, 0, "halt_frozen_down");
    ex(60, 0, 1, "halt_stall_held"); ex(60, 5, 1, "halt_fatal_held");
    run_to(5);
    err = 5'b00001;
    run_to(60);
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_fatal", 8'(fatal), 8'd0);
    chk("halt_rst_stall", 8'(stall), 8'd0);
    err = '0;
    #2 rst_n = 1'b1;
    chk("sb_drain2", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/razor_recovery_ctrl.md
Name: razor_recovery_ctrl

Overview:
Pipeline-level recovery controller for razor flip-flops. It collects the sticky per-stage error flags, stalls the pipeline, and selects the shadow-latch value into the erring stages. It flushes all stages downstream of the earliest error, then pulses the razor clear line. It also counts error events per time window and issues supply-voltage up/down requests to the DVS logic.

Parameters:
NUM_STAGES, 5, number of razor-protected pipeline stages (stage 0 = earliest)
REPLAY_CYCLES, 1, cycles restore_sel is held (1..15)
WINDOW, 256, error-rate observation window in cycles (>=2)
HI_THRESH, 4, events per window at or above which vdd_up pulses
CNT_W, 8, width of the saturating total-event counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
err_in  input  NUM_STAGES  razor error flags, sticky until cleared
stall  output  1  global pipeline stall
restore_sel  output  NUM_STAGES  per-stage select of the shadow-latch value
flush  output  NUM_STAGES  per-stage bubble insert
err_clr  output  1  active-high clear to all razor flops
recover_done  output  1  one-cycle pulse when recovery completes
fatal  output  1  sticky: error persisted through clear
vdd_up  output  1  one-cycle request to raise supply voltage
vdd_down  output  1  one-cycle request to lower supply voltage
err_total  output  CNT_W  saturating count of recovery events

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; err_total=0; window counters 0; latched error vector 0.
- All outputs are registered. Moore outputs follow state.
- IDLE: stall=0. When err_in!=0 at an edge: err_vec<=err_in, next state RESTORE. stall is first high in the following cycle.
- RESTORE: stall=1; restore_sel=err_vec.
  - Let m = lowest index set in err_vec. flush[i]=1 for i>m; flush[i]=0 for i<=m.
  - State lasts exactly REPLAY_CYCLES cycles, then CLEAR.
- CLEAR: stall=1, err_clr=1, restore_sel=0, flush=0. Lasts 1 cycle, then MASK.
- MASK: stall=1, err_clr=0. err_in is sampled at the end of MASK:
  - err_in==0: go to IDLE, recover_done=1 for one cycle (the first IDLE cycle).
  - err_in!=0: go to HALT.
- HALT: stall=1, fatal=1, all other control outputs 0. Exits only on reset.
- Stall length per event = REPLAY_CYCLES+2 cycles.
- Back-to-back events: new errors arriving during RESTORE/CLEAR are not merged into err_vec. A flag still set at MASK sends the controller to HALT.
- Event counting: one event per IDLE->RESTORE transition, regardless of how many bits are set.
  - err_total increments by 1 per event and saturates at 2^CNT_W-1.
- Window logic:
  - The cycle counter runs continuously, 0..WINDOW-1. The window ends on the cycle the counter wraps.
  - At window end: if win_events>=HI_THRESH, vdd_up=1 for 1 cycle. Else if win_events==0, vdd_down=1 for 1 cycle. Else neither.
  - win_events then resets to 0. An event on the same cycle as window end counts into the new window (win_events=1).
  - vdd_up and vdd_down are never both asserted.
  - win_events saturates at HI_THRESH.
  - Window logic is frozen while in HALT.
- Reset asserted mid-recovery: all outputs drop to 0 immediately. The razor flops must be cleared by system reset.

Test Plan:
1. NUM_STAGES=5, REPLAY_CYCLES=1. Drive err_in=5'b00100 at cycle 10, clear it when err_clr=1 → stall high cycles 11-13; restore_sel=00100 and flush=11000 in cycle 11; err_clr=1 in cycle 12; recover_done=1 in cycle 14; err_total=1.
2. Drive err_in=5'b01010 (multi-stage) → restore_sel=01010, flush=11100 (m=1); err_total increments by exactly 1.
3. Keep err_in=00001 stuck through CLEAR → HALT entered after MASK; fatal=1 and stall=1 held for 50+ cycles; assert reset=0 → fatal=0, stall=0 asynchronously.
4. WINDOW=16, HI_THRESH=2. Inject 2 events in window 0 and none in window 1 → vdd_up pulses at the end of window 0; vdd_down pulses at the end of window 1; never both.
5. Inject an event on the window-end cycle with a prior count of 1 → no vdd_up for the ending window; the new window starts with win_events=1.
6. CNT_W=3. Inject 9 events → err_total saturates at 7; assert reset=0 during RESTORE → all outputs 0 within the same cycle.
